conv_frame_loader: RTL and testbench

Write-side front end for the 5x5 convolution stage. Accepts a raster-ordered pixel stream over a valid/ready handshake, assembles a DATA_X x DATA_Y frame buffer, presents it as the parallel `data` array, and drives `conv_enable` until the convolution stage reports `conv_done` and downstream acknowledges the results. Sits between the image source (DMA/testbench stream) and the convolution layer.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/raster_counter.sv | 56 +++++
 rtl/conv_frame_loader.sv | 125 ++++++++++++
 tb/tb_conv_frame_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN convolution pipeline.
// The loader, convolution and weight blocks all size themselves from here.
package cnn_pkg;

    localparam int DATA_X      = 28;
    localparam int DATA_Y      = 28;
    localparam int DATA_SIZE   = 32;

    localparam int WEIGHT_X    = 5;
    localparam int WEIGHT_Y    = 5;
    localparam int WEIGHT_SIZE = 32;

    // A valid-only convolution shrinks each dimension by the kernel size minus one.
    localparam int CONV_X      = DATA_X - WEIGHT_X + 1;
    localparam int CONV_Y      = DATA_Y - WEIGHT_Y + 1;
    localparam int CONV_SIZE   = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position for frame loading.
// Column runs fastest; last_idx marks the final position of the frame.
module raster_counter #(
    parameter int DATA_X = 28,
    parameter int DATA_Y = 28,
    parameter int ROW_W  = $clog2(DATA_X),
    parameter int COL_W  = $clog2(DATA_Y)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_idx
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_end;
    logic             col_end;

    assign row_end  = (row_q == ROW_W'(DATA_X - 1));
    assign col_end  = (col_q == COL_W'(DATA_Y - 1));
    assign last_idx = row_end && col_end;
    assign row      = row_q;
    assign col      = col_q;

    // Clear wins over advance so a frame boundary always restarts at index 0.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv_frame_loader.sv
// Write-side front end of the 5x5 convolution stage: assembles a raster pixel
// stream into a frame buffer and holds conv_enable until results are acknowledged.
module conv_frame_loader #(
    parameter int DATA_X    = 28,
    parameter int DATA_Y    = 28,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [DATA_SIZE-1:0] pix_data,
    input  logic                 pix_last,
    output logic [DATA_SIZE-1:0] data [DATA_X][DATA_Y],
    output logic                 conv_enable,
    input  logic                 conv_done,
    input  logic                 result_ack,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);

    import cnn_pkg::*;

    localparam int ROW_W = $clog2(DATA_X);
    localparam int COL_W = $clog2(DATA_Y);

    loader_state_t        state_q, state_d;
    logic                 conv_enable_q, conv_enable_d;
    logic                 frame_err_q, frame_err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [DATA_SIZE-1:0] data_q [DATA_X][DATA_Y];
    logic [DATA_SIZE-1:0] data_d [DATA_X][DATA_Y];

    logic                 beat;
    logic                 cnt_clear;
    logic                 last_idx;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;

    raster_counter #(
        .DATA_X (DATA_X),
        .DATA_Y (DATA_Y),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_raster_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .advance  (beat),
        .row      (row),
        .col      (col),
        .last_idx (last_idx)
    );

    // Ready comes straight from the state flop so there is no input-to-ready path.
    assign pix_ready   = (state_q == LOAD);
    assign beat        = pix_valid && pix_ready;
    assign conv_enable = conv_enable_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign data        = data_q;

    always_comb begin
        state_d     = state_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        cnt_clear   = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (beat) begin
                    if (last_idx) begin
                        cnt_clear   = 1'b1;
                        state_d     = CONV;
                        frame_err_d = !pix_last;
                    end else if (pix_last) begin
                        cnt_clear   = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_d     = LOAD;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = LOAD;
        endcase
        // Enable follows the next state so it is registered yet aligned with the state change.
        conv_enable_d = (state_d != LOAD);
    end

    always_comb begin
        data_d = data_q;
        if (beat) begin
            data_d[row][col] = pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            conv_enable_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
            for (int x = 0; x < DATA_X; x++) begin
                for (int y = 0; y < DATA_Y; y++) begin
                    data_q[x][y] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            conv_enable_q <= conv_enable_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
            data_q        <= data_d;
        end
    end

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: table of frame scenarios plus
// hand-written ack/reset sequences, buffer checked against a beat scoreboard.
module tb_conv_frame_loader;

    localparam int NX   = 28;
    localparam int NY   = 28;
    localparam int NPIX = NX * NY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic [31:0] pix_data = '0;
    logic        conv_done = 1'b0;
    logic        result_ack = 1'b0;
    logic        pix_ready;
    logic        conv_enable;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [31:0] data [NX][NY];

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] val;
    } beat_t;

    typedef struct {
        string       name;
        int          nbeats;
        int          last_at;
        int          gap_pct;
        int          base;
        logic        exp_err;
        logic        exp_conv;
    } vec_t;

    beat_t       sb[$];
    logic [31:0] model_buf [NX][NY];
    vec_t        vecs [5];

    conv_frame_loader #(
        .DATA_X    (NX),
        .DATA_Y    (NY),
        .DATA_SIZE (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .data        (data),
        .conv_enable (conv_enable),
        .conv_done   (conv_done),
        .result_ack  (result_ack),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Retire scoreboard beats into the model, then compare the whole buffer.
    task automatic compareBuffer(input string name);
        beat_t b;
        int    bad = 0;
        int    fx = 0;
        int    fy = 0;
        while (sb.size() > 0) begin
            b = sb.pop_front();
            model_buf[b.x][b.y] = b.val;
        end
        for (int x = 0; x < NX; x++) begin
            for (int y = 0; y < NY; y++) begin
                if (data[x][y] !== model_buf[x][y]) begin
                    if (bad == 0) begin
                        fx = x;
                        fy = y;
                    end
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d entries differ, data[%0d][%0d] got %0d expected %0d",
                     name, bad, fx, fy, data[fx][fy], model_buf[fx][fy]);
        end
    endtask

    task automatic clearModel();
        sb.delete();
        for (int x = 0; x < NX; x++) begin
            for (int y = 0; y < NY; y++) begin
                model_buf[x][y] = '0;
            end
        end
    endtask

    task automatic applyStimulus(input int nbeats, input int last_at, input int gap_pct, input int base);
        for (int i = 0; i < nbeats; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_last  = 1'b0;
                stepCycle();
            end
            pix_valid = 1'b1;
            pix_data  = base + i;
            pix_last  = (i == last_at);
            sb.push_back('{i / NY, i % NY, 32'(base + i)});
            stepCycle();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Called while in CONV: raise done, sit in HOLD, acknowledge, then send a lagging done.
    task automatic finishConv(input string name);
        conv_done = 1'b1;
        stepCycle();
        conv_done = 1'b0;
        checkOutput({name, " hold enable"}, conv_enable, 1);
        checkOutput({name, " hold ready"}, pix_ready, 0);
        stepCycle();
        compareBuffer({name, " hold stable"});
        result_ack = 1'b1;
        stepCycle();
        result_ack = 1'b0;
        exp_cnt++;
        checkOutput({name, " ack enable"}, conv_enable, 0);
        checkOutput({name, " ack ready"}, pix_ready, 1);
        checkOutput({name, " frame_cnt"}, frame_cnt, 32'(exp_cnt));
        conv_done = 1'b1;
        stepCycle();
        conv_done = 1'b0;
        checkOutput({name, " late done ignored"}, conv_enable, 0);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " enable"}, conv_enable, 0);
        checkOutput({name, " frame_cnt"}, frame_cnt, 0);
        checkOutput({name, " frame_err"}, frame_err, 0);
        checkOutput({name, " ready"}, pix_ready, 1);
        clearModel();
        compareBuffer({name, " buffer zero"});
    endtask

    task automatic pulseReset(input string name);
        rst_n = 1'b0;
        #2;
        exp_cnt = 0;
        checkResetState(name);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
    endtask

    task automatic loadFullFrame(input string name, input int base);
        checkOutput({name, " idle enable"}, conv_enable, 0);
        applyStimulus(NPIX, NPIX - 1, 0, base);
        checkOutput({name, " enable"}, conv_enable, 1);
        checkOutput({name, " ready"}, pix_ready, 0);
        checkOutput({name, " frame_err"}, frame_err, 0);
        compareBuffer({name, " buffer"});
        stepCycle();
    endtask

    initial begin
        vecs[0] = '{"ramp",       NPIX, NPIX - 1, 0,  0,     1'b0, 1'b1};
        vecs[1] = '{"gaps",       NPIX, NPIX - 1, 50, 0,     1'b0, 1'b1};
        vecs[2] = '{"early_last", 401,  400,      0,  5000,  1'b1, 1'b0};
        vecs[3] = '{"after_err",  NPIX, NPIX - 1, 0,  10000, 1'b0, 1'b1};
        vecs[4] = '{"no_last",    NPIX, -1,       0,  20000, 1'b1, 1'b1};

        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("por");
        rst_n = 1'b1;
        stepCycle();

        for (int v = 0; v < 5; v++) begin
            checkOutput({vecs[v].name, " idle ready"}, pix_ready, 1);
            checkOutput({vecs[v].name, " idle enable"}, conv_enable, 0);
            applyStimulus(vecs[v].nbeats, vecs[v].last_at, vecs[v].gap_pct, vecs[v].base);
            checkOutput({vecs[v].name, " frame_err"}, frame_err, vecs[v].exp_err);
            checkOutput({vecs[v].name, " enable"}, conv_enable, vecs[v].exp_conv);
            checkOutput({vecs[v].name, " ready"}, pix_ready, !vecs[v].exp_conv);
            compareBuffer({vecs[v].name, " buffer"});
            if (v == 0) begin
                checkOutput("ramp data[1][0]", data[1][0], 28);
                checkOutput("ramp data[27][27]", data[27][27], 783);
            end
            stepCycle();
            checkOutput({vecs[v].name, " err pulse end"}, frame_err, 0);
            if (vecs[v].exp_conv) begin
                finishConv(vecs[v].name);
            end
        end

        // Ack while still in CONV must not release the frame.
        loadFullFrame("ack_in_conv", 30000);
        result_ack = 1'b1;
        stepCycle();
        stepCycle();
        result_ack = 1'b0;
        checkOutput("ack_in_conv enable", conv_enable, 1);
        checkOutput("ack_in_conv ready", pix_ready, 0);
        checkOutput("ack_in_conv frame_cnt", frame_cnt, 32'(exp_cnt));
        finishConv("ack_in_conv");

        // Reset partway through a frame, then a fresh frame from index 0.
        applyStimulus(300, -1, 0, 40000);
        pulseReset("rst_mid");
        loadFullFrame("after_rst_mid", 50000);
        finishConv("after_rst_mid");

        // Reset while holding results.
        loadFullFrame("pre_rst_hold", 60000);
        conv_done = 1'b1;
        stepCycle();
        conv_done = 1'b0;
        checkOutput("pre_rst_hold in hold", conv_enable, 1);
        pulseReset("rst_hold");
        loadFullFrame("after_rst_hold", 70000);
        finishConv("after_rst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
